// File: rtl/ni_defs_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ni_defs : shared network-interface types, widths and helpers       |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package ni_defs;

   localparam int CORE_ADDR_W = 2;
   localparam int MEM_ADDR_W  = 4;
   localparam int DATA_W      = 8;

   typedef enum logic [0:0] {
      TX_WR = 1'b0,
      TX_RD = 1'b1
   } tx_kind_t;

   typedef struct packed {
      tx_kind_t                kind;
      logic [CORE_ADDR_W-1:0]  core_addr;
      logic [MEM_ADDR_W-1:0]   mem_addr;
      logic [DATA_W-1:0]       data;
      logic                    acq_rel;
   } tx_t;

   typedef struct packed {
      logic [MEM_ADDR_W-1:0]   mem_addr;
      logic                    acq;
   } ot_entry_t;

   // Width of a counter that must hold 0..max_out inclusive.
   function automatic int cnt_w(input int max_out);
      return $clog2(max_out + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/link.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | link : valid/ready transaction channel between NI endpoints        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface link;
   import ni_defs::*;

   logic src_rdy;
   logic tgt_rdy;
   tx_t  tx;

   modport egress  (output src_rdy, output tx, input tgt_rdy);
   modport ingress (input src_rdy, input tx, output tgt_rdy);

endinterface
`default_nettype wire

// File: rtl/core_ot_table.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | core_ot_table : ordered, compacting outstanding-read table         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module core_ot_table
   import ni_defs::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = cnt_w(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alloc,
   input  ot_entry_t             alloc_entry,
   input  logic [MEM_ADDR_W-1:0] lookup_addr,
   input  logic                  retire,
   output logic                  hit,
   output ot_entry_t             hit_entry,
   output logic [CNT_W-1:0]      count,
   output logic                  head_removed,
   output logic                  any_acq
);

   ot_entry_t        r_ent [DEPTH];
   logic [CNT_W-1:0] r_cnt;

   ot_entry_t        w_next [DEPTH];
   logic [CNT_W-1:0] w_idx;
   logic [CNT_W-1:0] w_cnt_mid;
   logic [CNT_W-1:0] w_cnt_next;
   logic             w_do_ret;

   // Descending scan so the lowest (oldest) matching slot wins.
   always_comb begin
      hit       = 1'b0;
      hit_entry = '0;
      w_idx     = '0;
      any_acq   = 1'b0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (CNT_W'(i) < r_cnt && r_ent[i].mem_addr == lookup_addr) begin
            hit       = 1'b1;
            hit_entry = r_ent[i];
            w_idx     = CNT_W'(i);
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (CNT_W'(i) < r_cnt && r_ent[i].acq) begin
            any_acq = 1'b1;
         end
      end
   end

   always_comb begin
      w_do_ret   = retire & hit;
      w_next     = r_ent;
      w_cnt_mid  = r_cnt;
      if (w_do_ret) begin
         for (int i = 0; i < DEPTH - 1; i++) begin
            if (CNT_W'(i) >= w_idx) begin
               w_next[i] = r_ent[i + 1];
            end
         end
         w_cnt_mid = r_cnt - CNT_W'(1);
      end
      w_cnt_next = w_cnt_mid;
      // Append after compaction so a same-cycle retire frees the slot first.
      if (alloc) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i) == w_cnt_mid) begin
               w_next[i] = alloc_entry;
            end
         end
         w_cnt_next = w_cnt_mid + CNT_W'(1);
      end
   end

   assign head_removed = w_do_ret && (w_idx == '0);
   assign count        = r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_ent[i] <= '0;
         end
      end else begin
         r_cnt <= w_cnt_next;
         r_ent <= w_next;
      end
   end

endmodule
`default_nettype wire

// File: rtl/core_mo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | core_mo : multi-outstanding core model with acquire/release rules  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module core_mo
   import ni_defs::*;
#(
   parameter logic [CORE_ADDR_W-1:0] CORE_ADDR       = '0,
   parameter int                     MAX_OUTSTANDING = 4,
   parameter int                     ACQ_REL_EN      = 1,
   parameter int                     TIMEOUT         = 64,
   localparam int                    CNT_W           = cnt_w(MAX_OUTSTANDING)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  tx_kind_t              req_kind,
   input  logic [MEM_ADDR_W-1:0] req_mem_addr,
   input  logic [DATA_W-1:0]     req_data,
   input  logic                  req_acq_rel,
   link.egress                   wpath,
   link.ingress                  rpath,
   output logic                  rsp_valid,
   output logic [MEM_ADDR_W-1:0] rsp_mem_addr,
   output logic [DATA_W-1:0]     rsp_data,
   output logic                  rsp_acq,
   output logic [CNT_W-1:0]      outstanding,
   output logic                  err_unexpected,
   output logic                  timeout
);

   localparam int               AGE_W     = $clog2(TIMEOUT + 1);
   localparam logic [AGE_W-1:0] c_timeout = AGE_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] c_max     = CNT_W'(MAX_OUTSTANDING);
   localparam logic             c_acq_en  = (ACQ_REL_EN != 0);

   logic                  r_rsp_valid;
   logic [MEM_ADDR_W-1:0] r_rsp_mem_addr;
   logic [DATA_W-1:0]     r_rsp_data;
   logic                  r_rsp_acq;
   logic                  r_err;
   logic                  r_timeout;
   logic [AGE_W-1:0]      r_age;

   logic                  w_can_issue;
   logic                  w_alloc;
   logic                  w_rx;
   logic                  w_match_ok;
   logic                  w_hit;
   logic                  w_retire;
   logic                  w_bad;
   logic                  w_head_removed;
   logic                  w_any_acq;
   logic [CNT_W-1:0]      w_cnt;
   logic [AGE_W-1:0]      w_age_next;
   ot_entry_t             w_hit_entry;
   ot_entry_t             w_alloc_entry;
   logic                  w_unused_acq_rel;

   // Gating looks only at registered table state; rpath never reaches wpath.
   assign w_can_issue = rst_n
                      & ~((req_kind == TX_RD) && (w_cnt == c_max))
                      & ~(c_acq_en && w_any_acq)
                      & ~(c_acq_en && (req_kind == TX_WR) && req_acq_rel && (w_cnt != '0));

   assign wpath.src_rdy = req_valid & w_can_issue;
   assign req_ready     = wpath.tgt_rdy & w_can_issue;
   assign wpath.tx      = '{kind:      req_kind,
                            core_addr: CORE_ADDR,
                            mem_addr:  req_mem_addr,
                            data:      (req_kind == TX_WR) ? req_data : '0,
                            acq_rel:   c_acq_en & req_acq_rel};

   assign w_alloc       = req_valid & req_ready & (req_kind == TX_RD);
   assign w_alloc_entry = '{mem_addr: req_mem_addr, acq: c_acq_en & req_acq_rel};

   assign rpath.tgt_rdy    = 1'b1;
   assign w_rx             = rpath.src_rdy & rpath.tgt_rdy;
   assign w_match_ok       = (rpath.tx.kind == TX_RD) && (rpath.tx.core_addr == CORE_ADDR);
   assign w_retire         = w_rx & w_match_ok & w_hit;
   assign w_bad            = w_rx & ~w_retire;
   assign w_unused_acq_rel = rpath.tx.acq_rel;

   core_ot_table #(
      .DEPTH (MAX_OUTSTANDING),
      .CNT_W (CNT_W)
   ) u_table (
      .clk          (clk),
      .rst_n        (rst_n),
      .alloc        (w_alloc),
      .alloc_entry  (w_alloc_entry),
      .lookup_addr  (rpath.tx.mem_addr),
      .retire       (w_rx & w_match_ok),
      .hit          (w_hit),
      .hit_entry    (w_hit_entry),
      .count        (w_cnt),
      .head_removed (w_head_removed),
      .any_acq      (w_any_acq)
   );

   always_comb begin
      w_age_next = r_age;
      if (w_cnt == '0 || w_head_removed) begin
         w_age_next = '0;
      end else if (r_age != c_timeout) begin
         w_age_next = r_age + AGE_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid    <= 1'b0;
         r_rsp_mem_addr <= '0;
         r_rsp_data     <= '0;
         r_rsp_acq      <= 1'b0;
         r_err          <= 1'b0;
         r_timeout      <= 1'b0;
         r_age          <= '0;
      end else begin
         r_rsp_valid <= w_retire;
         if (w_retire) begin
            r_rsp_mem_addr <= w_hit_entry.mem_addr;
            r_rsp_data     <= rpath.tx.data;
            r_rsp_acq      <= w_hit_entry.acq;
         end
         r_err     <= r_err | w_bad;
         r_age     <= w_age_next;
         r_timeout <= r_timeout | (w_age_next == c_timeout);
      end
   end

   assign rsp_valid      = r_rsp_valid;
   assign rsp_mem_addr   = r_rsp_mem_addr;
   assign rsp_data       = r_rsp_data;
   assign rsp_acq        = r_rsp_acq;
   assign outstanding    = w_cnt;
   assign err_unexpected = r_err;
   assign timeout        = r_timeout;

   a_cnt_bound : assert property (@(posedge clk) disable iff (!rst_n)
      outstanding <= c_max);
   a_acq_block : assert property (@(posedge clk) disable iff (!rst_n)
      (c_acq_en && w_any_acq) |-> !(wpath.src_rdy && wpath.tgt_rdy));
   a_rx_result : assert property (@(posedge clk) disable iff (!rst_n)
      rpath.src_rdy |=> (rsp_valid || err_unexpected));

endmodule
`default_nettype wire

// File: tb/tb_core_mo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_core_mo : directed self-checking bench for core_mo              |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_core_mo;
   import ni_defs::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   tx_kind_t   req_kind;
   logic [3:0] req_mem_addr;
   logic [7:0] req_data;
   logic       req_acq_rel;
   logic       rsp_valid;
   logic [3:0] rsp_mem_addr;
   logic [7:0] rsp_data;
   logic       rsp_acq;
   logic [2:0] outstanding;
   logic       err_unexpected;
   logic       timeout;

   int total = 0;
   int bad   = 0;

   link wp();
   link rp();

   always #5 clk = ~clk;

   core_mo #(
      .CORE_ADDR       (2'd1),
      .MAX_OUTSTANDING (4),
      .ACQ_REL_EN      (1),
      .TIMEOUT         (8)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_kind       (req_kind),
      .req_mem_addr   (req_mem_addr),
      .req_data       (req_data),
      .req_acq_rel    (req_acq_rel),
      .wpath          (wp),
      .rpath          (rp),
      .rsp_valid      (rsp_valid),
      .rsp_mem_addr   (rsp_mem_addr),
      .rsp_data       (rsp_data),
      .rsp_acq        (rsp_acq),
      .outstanding    (outstanding),
      .err_unexpected (err_unexpected),
      .timeout        (timeout)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      req_valid    = 1'b0;
      req_kind     = TX_RD;
      req_mem_addr = '0;
      req_data     = '0;
      req_acq_rel  = 1'b0;
      rp.src_rdy   = 1'b0;
      rp.tx        = '0;
   endtask

   task automatic offer(input tx_kind_t k, input logic [3:0] a, input logic [7:0] d, input logic acq);
      req_valid    = 1'b1;
      req_kind     = k;
      req_mem_addr = a;
      req_data     = d;
      req_acq_rel  = acq;
   endtask

   task automatic respond(input tx_kind_t k, input logic [1:0] c, input logic [3:0] a, input logic [7:0] d);
      rp.src_rdy = 1'b1;
      rp.tx      = '{kind: k, core_addr: c, mem_addr: a, data: d, acq_rel: 1'b0};
   endtask

   task automatic do_reset;
      idle();
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset;
      idle();
      rst_n = 1'b0;
      offer(TX_WR, 4'd3, 8'h12, 1'b0);
      respond(TX_RD, 2'd1, 4'd3, 8'hee);
      tick();
      tick();
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL rst_req_ready got=%0b want=0", req_ready); end
      total++; if (wp.src_rdy !== 1'b0) begin bad++; $display("FAIL rst_src_rdy got=%0b want=0", wp.src_rdy); end
      total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL rst_outstanding got=%0d want=0", outstanding); end
      total++; if ({rsp_valid, rsp_mem_addr, rsp_data, rsp_acq} !== 14'd0) begin bad++;
         $display("FAIL rst_rsp got=%0b/%0h/%0h/%0b want=0/0/0/0", rsp_valid, rsp_mem_addr, rsp_data, rsp_acq); end
      total++; if ({err_unexpected, timeout} !== 2'b00) begin bad++;
         $display("FAIL rst_flags got=%0b%0b want=00", err_unexpected, timeout); end
      idle();
      rst_n = 1'b1;
      tick();
      total++; if (err_unexpected !== 1'b0) begin bad++; $display("FAIL rst_rpath_ignored got=%0b want=0", err_unexpected); end
   endtask

   task automatic test_back_to_back;
      tx_t exp;
      do_reset();
      offer(TX_RD, 4'd1, 8'hAA, 1'b0);
      #1;
      exp = '{kind: TX_RD, core_addr: 2'd1, mem_addr: 4'd1, data: 8'h00, acq_rel: 1'b0};
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_first_ready got=%0b want=1", req_ready); end
      total++; if (wp.tx !== exp) begin bad++; $display("FAIL b2b_first_tx got=%h want=%h", wp.tx, exp); end
      tick();
      offer(TX_RD, 4'd2, 8'hAA, 1'b0);
      tick();
      offer(TX_RD, 4'd1, 8'hAA, 1'b0);
      tick();
      offer(TX_RD, 4'd3, 8'hAA, 1'b0);
      tick();
      total++; if (outstanding !== 3'd4) begin bad++; $display("FAIL b2b_full_cnt got=%0d want=4", outstanding); end
      offer(TX_RD, 4'd5, 8'h00, 1'b0);
      #1;
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_fifth_ready got=%0b want=0", req_ready); end
      total++; if (wp.src_rdy !== 1'b0) begin bad++; $display("FAIL b2b_fifth_src got=%0b want=0", wp.src_rdy); end
      tick();
      total++; if (outstanding !== 3'd4) begin bad++; $display("FAIL b2b_hold_cnt got=%0d want=4", outstanding); end
      // Slot freed by this retire is usable only from the next cycle.
      respond(TX_RD, 2'd1, 4'd1, 8'h11);
      #1;
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL b2b_same_cycle_ready got=%0b want=0", req_ready); end
      tick();
      total++; if ({rsp_valid, rsp_mem_addr, rsp_data} !== {1'b1, 4'd1, 8'h11}) begin bad++;
         $display("FAIL b2b_rsp1 got=%0b/%0h/%0h want=1/1/11", rsp_valid, rsp_mem_addr, rsp_data); end
      total++; if (outstanding !== 3'd3) begin bad++; $display("FAIL b2b_cnt_after1 got=%0d want=3", outstanding); end
      respond(TX_RD, 2'd1, 4'd1, 8'h22);
      #1;
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL b2b_next_cycle_ready got=%0b want=1", req_ready); end
      tick();
      req_valid = 1'b0;
      total++; if ({rsp_valid, rsp_mem_addr, rsp_data} !== {1'b1, 4'd1, 8'h22}) begin bad++;
         $display("FAIL b2b_rsp2 got=%0b/%0h/%0h want=1/1/22", rsp_valid, rsp_mem_addr, rsp_data); end
      total++; if (outstanding !== 3'd3) begin bad++; $display("FAIL b2b_issue_retire_cnt got=%0d want=3", outstanding); end
      respond(TX_RD, 2'd1, 4'd3, 8'h33);
      tick();
      total++; if ({rsp_valid, rsp_mem_addr, rsp_data, outstanding} !== {1'b1, 4'd3, 8'h33, 3'd2}) begin bad++;
         $display("FAIL b2b_rsp3 got=%0b/%0h/%0h/%0d want=1/3/33/2", rsp_valid, rsp_mem_addr, rsp_data, outstanding); end
      respond(TX_RD, 2'd1, 4'd2, 8'h44);
      tick();
      total++; if ({rsp_valid, rsp_mem_addr, rsp_data, outstanding} !== {1'b1, 4'd2, 8'h44, 3'd1}) begin bad++;
         $display("FAIL b2b_rsp4 got=%0b/%0h/%0h/%0d want=1/2/44/1", rsp_valid, rsp_mem_addr, rsp_data, outstanding); end
      respond(TX_RD, 2'd1, 4'd5, 8'h55);
      tick();
      total++; if ({rsp_valid, rsp_mem_addr, rsp_data, outstanding} !== {1'b1, 4'd5, 8'h55, 3'd0}) begin bad++;
         $display("FAIL b2b_rsp5 got=%0b/%0h/%0h/%0d want=1/5/55/0", rsp_valid, rsp_mem_addr, rsp_data, outstanding); end
      idle();
      tick();
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL b2b_pulse_end got=%0b want=0", rsp_valid); end
      total++; if (err_unexpected !== 1'b0) begin bad++; $display("FAIL b2b_no_err got=%0b want=0", err_unexpected); end
   endtask

   task automatic test_acquire;
      do_reset();
      offer(TX_RD, 4'd2, 8'h00, 1'b1);
      #1;
      total++; if (wp.tx.acq_rel !== 1'b1) begin bad++; $display("FAIL acq_tx_flag got=%0b want=1", wp.tx.acq_rel); end
      tick();
      offer(TX_WR, 4'd5, 8'h55, 1'b0);
      #1;
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL acq_block0 got=%0b want=0", req_ready); end
      tick();
      respond(TX_RD, 2'd1, 4'd2, 8'h77);
      #1;
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL acq_block_rsp got=%0b want=0", req_ready); end
      tick();
      rp.src_rdy = 1'b0;
      #1;
      total++; if ({rsp_valid, rsp_acq, rsp_mem_addr, rsp_data} !== {1'b1, 1'b1, 4'd2, 8'h77}) begin bad++;
         $display("FAIL acq_rsp got=%0b/%0b/%0h/%0h want=1/1/2/77", rsp_valid, rsp_acq, rsp_mem_addr, rsp_data); end
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL acq_unblock got=%0b want=1", req_ready); end
      tick();
      idle();
      total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL acq_wr_noalloc got=%0d want=0", outstanding); end
   endtask

   task automatic test_release;
      tx_t exp;
      do_reset();
      offer(TX_RD, 4'd3, 8'h00, 1'b0);
      tick();
      offer(TX_RD, 4'd4, 8'h00, 1'b0);
      tick();
      offer(TX_WR, 4'd6, 8'h66, 1'b1);
      #1;
      total++; if (req_ready !== 1'b0 || outstanding !== 3'd2) begin bad++;
         $display("FAIL rel_hold2 got=%0b/%0d want=0/2", req_ready, outstanding); end
      respond(TX_RD, 2'd1, 4'd3, 8'h01);
      tick();
      total++; if (req_ready !== 1'b0 || outstanding !== 3'd1) begin bad++;
         $display("FAIL rel_hold1 got=%0b/%0d want=0/1", req_ready, outstanding); end
      respond(TX_RD, 2'd1, 4'd4, 8'h02);
      tick();
      rp.src_rdy = 1'b0;
      #1;
      exp = '{kind: TX_WR, core_addr: 2'd1, mem_addr: 4'd6, data: 8'h66, acq_rel: 1'b1};
      total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rel_go got=%0b want=1", req_ready); end
      total++; if (wp.tx !== exp) begin bad++; $display("FAIL rel_tx got=%h want=%h", wp.tx, exp); end
      tick();
      idle();
      total++; if (err_unexpected !== 1'b0) begin bad++; $display("FAIL rel_no_err got=%0b want=0", err_unexpected); end
   endtask

   task automatic test_errors;
      do_reset();
      offer(TX_RD, 4'd7, 8'h00, 1'b0);
      tick();
      req_valid = 1'b0;
      respond(TX_RD, 2'd0, 4'd7, 8'h99);
      tick();
      rp.src_rdy = 1'b0;
      total++; if ({err_unexpected, rsp_valid, outstanding} !== {1'b1, 1'b0, 3'd1}) begin bad++;
         $display("FAIL err_core got=%0b/%0b/%0d want=1/0/1", err_unexpected, rsp_valid, outstanding); end
      tick();
      total++; if (err_unexpected !== 1'b1) begin bad++; $display("FAIL err_sticky got=%0b want=1", err_unexpected); end
      do_reset();
      offer(TX_RD, 4'd7, 8'h00, 1'b0);
      tick();
      req_valid = 1'b0;
      respond(TX_RD, 2'd1, 4'd9, 8'h99);
      tick();
      rp.src_rdy = 1'b0;
      total++; if ({err_unexpected, rsp_valid, outstanding} !== {1'b1, 1'b0, 3'd1}) begin bad++;
         $display("FAIL err_addr got=%0b/%0b/%0d want=1/0/1", err_unexpected, rsp_valid, outstanding); end
      do_reset();
      offer(TX_RD, 4'd7, 8'h00, 1'b0);
      tick();
      req_valid = 1'b0;
      respond(TX_WR, 2'd1, 4'd7, 8'h99);
      tick();
      rp.src_rdy = 1'b0;
      total++; if ({err_unexpected, rsp_valid, outstanding} !== {1'b1, 1'b0, 3'd1}) begin bad++;
         $display("FAIL err_kind got=%0b/%0b/%0d want=1/0/1", err_unexpected, rsp_valid, outstanding); end
   endtask

   task automatic test_timeout;
      do_reset();
      offer(TX_RD, 4'd6, 8'h00, 1'b1);
      tick();
      req_valid = 1'b0;
      respond(TX_RD, 2'd1, 4'd6, 8'h5A);
      tick();
      rp.src_rdy = 1'b0;
      offer(TX_RD, 4'd5, 8'h00, 1'b0);
      tick();
      req_valid = 1'b0;
      repeat (7) tick();
      total++; if (timeout !== 1'b0) begin bad++; $display("FAIL to_early got=%0b want=0", timeout); end
      tick();
      total++; if (timeout !== 1'b1) begin bad++; $display("FAIL to_set got=%0b want=1", timeout); end
      offer(TX_WR, 4'd1, 8'h10, 1'b0);
      rst_n = 1'b0;
      #1;
      total++; if ({timeout, err_unexpected, outstanding} !== 5'd0) begin bad++;
         $display("FAIL to_rst_state got=%0b/%0b/%0d want=0/0/0", timeout, err_unexpected, outstanding); end
      total++; if ({rsp_valid, rsp_mem_addr, rsp_data, rsp_acq} !== 14'd0) begin bad++;
         $display("FAIL to_rst_rsp got=%0b/%0h/%0h/%0b want=0/0/0/0", rsp_valid, rsp_mem_addr, rsp_data, rsp_acq); end
      total++; if (req_ready !== 1'b0 || wp.src_rdy !== 1'b0) begin bad++;
         $display("FAIL to_rst_issue got=%0b/%0b want=0/0", req_ready, wp.src_rdy); end
      idle();
      tick();
      rst_n = 1'b1;
      respond(TX_RD, 2'd1, 4'd5, 8'h00);
      tick();
      rp.src_rdy = 1'b0;
      total++; if ({err_unexpected, rsp_valid, outstanding} !== {1'b1, 1'b0, 3'd0}) begin bad++;
         $display("FAIL to_stale_rsp got=%0b/%0b/%0d want=1/0/0", err_unexpected, rsp_valid, outstanding); end
   endtask

   initial begin
      #50000;
      $display("FAIL sim_time_limit got=expired want=finished");
      $fatal(1);
   end

   initial begin
      rst_n      = 1'b0;
      wp.tgt_rdy = 1'b1;
      idle();
      test_reset();
      test_back_to_back();
      test_acquire();
      test_release();
      test_errors();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/core_mo.md
# core_mo

Multi-outstanding successor of the stalling core model. It sits at the core end of the network interface, between a request source (bench or formal free inputs) and the `link` pair. It issues reads and writes on `wpath` and tracks up to `MAX_OUTSTANDING` in-flight `TX_RD` in an ordered table. It retires responses from `rpath` by `mem_addr` match, enforces acquire/release ordering, and flags protocol errors and stuck reads.

## Interface
- `CORE_ADDR`, 0: this core's address; stamped into every issued `tx.core_addr`.
- `MAX_OUTSTANDING`, 4: read-table depth, ≥1.
- `ACQ_REL_EN`, 1: 1 enables the acquire/release ordering rules; 0 forces `tx.acq_rel`=0 and ignores `req_acq_rel`.
- `TIMEOUT`, 64: cycles the oldest read may wait before `timeout` sets, ≥1.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request offered.
- `req_ready` out 1: request accepted this cycle when `req_valid` is also high.
- `req_kind` in `tx_kind_t`: `TX_WR` or `TX_RD`.
- `req_mem_addr` in `MEM_ADDR_W`: target memory.
- `req_data` in `DATA_W`: write data. Ignored for reads.
- `req_acq_rel` in 1: acquire (on `TX_RD`) or release (on `TX_WR`).
- `wpath` `link.egress`: outgoing transactions.
- `rpath` `link.ingress`: returning read responses.
- `rsp_valid` out 1: one-cycle pulse for a retired read.
- `rsp_mem_addr` out `MEM_ADDR_W`: address of the retired read.
- `rsp_data` out `DATA_W`: data of the retired read.
- `rsp_acq` out 1: the retired read was an acquire.
- `outstanding` out `CNT_W`=$clog2(MAX_OUTSTANDING+1): number of table entries.
- `err_unexpected` out 1: sticky protocol-error flag.
- `timeout` out 1: sticky watchdog flag.

## Operation
- A transfer on either link occurs when `src_rdy & tgt_rdy`.
- Issue path is combinational:
  - `wpath.src_rdy = req_valid & can_issue`.
  - `req_ready = wpath.tgt_rdy & can_issue`.
  - `wpath.tx = {req_kind, CORE_ADDR, req_mem_addr, kind==TX_WR ? req_data : 0, ACQ_REL_EN & req_acq_rel}`.
- `can_issue` is computed from registered state only, with no path from `rpath` to `wpath`. It is low when any of these holds:
  - request is `TX_RD` and `outstanding==MAX_OUTSTANDING`;
  - `ACQ_REL_EN` and any table entry has `acq` set (all traffic blocked until the acquire retires);
  - `ACQ_REL_EN`, request is a release `TX_WR`, and `outstanding!=0`.
- Plain `TX_WR` never allocates a table entry.
- Table: entries ordered oldest-first; each entry holds `{mem_addr, acq}`. An issued `TX_RD` appends at the tail.
- `rpath.tgt_rdy` is constantly 1.
- On an `rpath` transfer with `kind==TX_RD`, `core_addr==CORE_ADDR` and a matching entry:
  - the oldest entry with equal `mem_addr` is removed;
  - younger entries compact toward the head.
- If the `rpath` transfer has the wrong `kind`, the wrong `core_addr`, or no matching entry:
  - `err_unexpected` sets;
  - the table is unchanged;
  - no `rsp_valid` pulse.
- Simultaneous issue and retire in one cycle:
  - retire matches only entries present at the start of the cycle;
  - the new entry appends after compaction;
  - `outstanding` is unchanged.
- Watchdog:
  - `age` counts cycles while the table is non-empty and saturates at `TIMEOUT`;
  - `age` clears when the head entry is removed or the table is empty;
  - `timeout` sets when `age==TIMEOUT`.
- Both `err_unexpected` and `timeout` clear only on reset.

## Timing
- Reset values: table empty, `outstanding`=0, `age`=0, `rsp_valid`=0, `rsp_mem_addr`=0, `rsp_data`=0, `rsp_acq`=0, `err_unexpected`=0, `timeout`=0.
- While in reset the block issues nothing: `wpath.src_rdy`=0 and `req_ready`=0.
- `rpath` is ignored during reset.
- Issue latency is 0: the same-cycle handshake.
- `outstanding` updates on the clock edge after the transfer.
- `rsp_*` is registered: it pulses one cycle after the `rpath` transfer, for exactly one cycle.
- A slot freed in cycle N is usable for issue in cycle N+1.
- Reset mid-operation drops all entries. A response arriving after reset for a pre-reset read sets `err_unexpected`.

## Structure
- Add to `ni_defs`:
  - `ot_entry_t` packed `{logic [MEM_ADDR_W-1:0] mem_addr; logic acq;}`;
  - the `CNT_W` helper function.
- Sub-module `core_ot_table`:
  - ports: alloc, alloc entry, lookup addr/retire, hit, hit entry, count, head_removed, any_acq;
  - implements the ordered compacting table.
- `core_mo` holds the issue gating, response register, watchdog and error flags.
- Properties to include:
  - `outstanding<=MAX_OUTSTANDING`;
  - no `wpath` transfer while an acquire is outstanding;
  - `rpath` transfer ⇒ `rsp_valid` or `err_unexpected` next cycle.

## Test plan
- Four `TX_RD` to mem 1,2,1,3 issued back-to-back, then a fifth `TX_RD` → `req_ready`=0 on the fifth, `outstanding`=4.
- Responses returned in order 1,1,3,2 → retire order is the first-issued mem-1 entry, then the second, then 3, then 2; `outstanding` reaches 0; no error.
- Acquire `TX_RD` to mem 2, then a `TX_WR` offered → `req_ready`=0 until one cycle after the mem-2 response; `rsp_acq`=1.
- Release `TX_WR` with two reads outstanding → held until `outstanding`=0, then issues with `tx.acq_rel`=1.
- Response with `core_addr!=CORE_ADDR`, or to an unissued mem address → `err_unexpected`=1, `outstanding` unchanged, no `rsp_valid`.
- With `TIMEOUT`=8, one read never answered → `timeout`=1 on the 8th cycle after issue; assert `rst_n` low mid-test → all outputs return to their reset values immediately.
